fifo_bank_drain: RTL and testbench

FIFO_BANK_DRAIN -- requirements
Module: fifo_bank_drain

---
 rtl/fifo_bank_drain_pkg.sv | 14 +
 rtl/fifo_bank_drain_sync_fifo_lane.sv | 55 +++++
 rtl/fifo_bank_drain.sv | 114 +++++++++++
 tb/tb_fifo_bank_drain.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_bank_drain_pkg.sv
// Shared definitions for the FIFO bank drain block and its fill controller.
package fifo_bank_drain_pkg;

   localparam int unsigned data_size_default  = 8;
   localparam int unsigned array_size_default = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_bank_drain_sync_fifo_lane.sv
// Single FIFO lane: register-array storage, wrapping pointers, occupancy count.
// A push to a full lane is dropped and reported on overflow.
module sync_fifo_lane
   import fifo_bank_drain_pkg::*;
#(
   parameter int data_size  = data_size_default,
   parameter int fifo_depth = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [data_size-1:0]          din,
   output logic [data_size-1:0]          dout,
   output logic [$clog2(fifo_depth):0]   count,
   output logic                          overflow
);

   localparam int ptr_w = $clog2(fifo_depth);
   localparam int cnt_w = ptr_w + 1;

   logic [data_size-1:0] mem [fifo_depth];
   logic [ptr_w-1:0]     wr_ptr;
   logic [ptr_w-1:0]     rd_ptr;
   logic                 push_ok;
   logic                 pop_ok;

   assign push_ok  = push && (count < cnt_w'(fifo_depth));
   assign pop_ok   = pop && (count != '0);
   assign overflow = push && !push_ok;
   assign dout     = mem[rd_ptr];

   // Pointer and count bookkeeping; pointers wrap by their natural width.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ptr_w'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + cnt_w'(1);
            2'b01:   count <= count - cnt_w'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; strobes during reset are ignored.
   always_ff @(posedge clk) begin
      if (reset && push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fifo_bank_drain.sv
// Bank of per-lane FIFOs filled one word at a time and drained as aligned
// columns. Tracks end-of-input, flags overflow and misaligned lane depths.
//
// state | meaning
// IDLE  | after reset, waiting for enable
// RUN   | accepting writes, popping columns on request
// FLUSH | input complete, draining remaining columns
// DONE  | drained (or misaligned), pops inhibited until reset
module fifo_bank_drain
   import fifo_bank_drain_pkg::*;
#(
   parameter int data_size   = data_size_default,
   parameter int array_size  = array_size_default,
   parameter int fifo_depth  = 16,
   parameter int full_margin = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [data_size-1:0]             bus,
   input  logic [array_size-1:0]            write_enable_in,
   input  logic                             completed_in,
   input  logic                             read_request,
   output logic [array_size-1:0]            full_out,
   output logic [array_size-1:0]            empty_out,
   output logic [array_size*data_size-1:0]  data_out,
   output logic                             valid_out,
   output logic                             drained,
   output logic [1:0]                       error
);

   localparam int cnt_w = $clog2(fifo_depth) + 1;
   localparam logic [cnt_w-1:0] full_level = cnt_w'(fifo_depth - full_margin);

   state_t                        state;
   state_t                        state_next;
   logic                          completed_q;
   logic                          pop_fire;
   logic                          any_empty;
   logic                          all_empty;
   logic                          multi_hot;
   logic                          misalign;
   logic [array_size-1:0]         lane_ovf;
   logic [array_size*data_size-1:0] column;
   logic [cnt_w-1:0]              count [array_size];

   for (genvar k = 0; k < array_size; k++) begin : g_lane
      sync_fifo_lane #(
         .data_size  (data_size),
         .fifo_depth (fifo_depth)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .push     (write_enable_in[k]),
         .pop      (pop_fire),
         .din      (bus),
         .dout     (column[k*data_size +: data_size]),
         .count    (count[k]),
         .overflow (lane_ovf[k])
      );
      assign full_out[k]  = (count[k] >= full_level);
      assign empty_out[k] = (count[k] == '0);
   end

   assign any_empty = |empty_out;
   assign all_empty = &empty_out;
   assign multi_hot = |(write_enable_in & (write_enable_in - array_size'(1)));
   assign pop_fire  = enable && read_request && !any_empty &&
                      ((state == RUN) || (state == FLUSH));
   assign misalign  = (state == FLUSH) && enable && any_empty && !all_empty;
   assign drained   = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode; every transition waits for enable.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (enable) state_next = RUN;
         RUN:   if (enable && (completed_in || completed_q)) state_next = FLUSH;
         FLUSH: if (enable && any_empty) state_next = DONE;
         DONE:  state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // End-of-input latch and sticky error flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         completed_q <= 1'b0;
         error       <= 2'b00;
      end else begin
         if (completed_in)            completed_q <= 1'b1;
         if (multi_hot || |lane_ovf)  error[0]    <= 1'b1;
         if (misalign)                error[1]    <= 1'b1;
      end
   end

   // Registered column output, one cycle after the pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         valid_out <= pop_fire;
         if (pop_fire) data_out <= column;
      end
   end

endmodule

// File: tb/tb_fifo_bank_drain.sv
// Bench for fifo_bank_drain: lane queue model with a column scoreboard,
// a vector table for the basic fill/pop pass, and directed corner sequences.
module tb_fifo_bank_drain;
   import fifo_bank_drain_pkg::*;

   localparam int depth = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  bus;
   logic [8:0]  write_enable_in;
   logic        completed_in;
   logic        read_request;
   logic [8:0]  full_out;
   logic [8:0]  empty_out;
   logic [71:0] data_out;
   logic        valid_out;
   logic        drained;
   logic [1:0]  error;

   always #5 clk = ~clk;

   fifo_bank_drain dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .bus             (bus),
      .write_enable_in (write_enable_in),
      .completed_in    (completed_in),
      .read_request    (read_request),
      .full_out        (full_out),
      .empty_out       (empty_out),
      .data_out        (data_out),
      .valid_out       (valid_out),
      .drained         (drained),
      .error           (error)
   );

   logic [4:0] cnt [9];
   for (genvar k = 0; k < 9; k++) begin : g_cnt
      assign cnt[k] = dut.g_lane[k].u_lane.count;
   end

   int checks = 0;
   int errors = 0;

   logic [7:0]  mq [9][$];
   logic [71:0] sb [$];
   state_t      mstate;
   logic        mcomp;
   logic [1:0]  merr;

   typedef struct {
      logic [8:0]  we;
      logic [7:0]  bus;
      logic        rr;
      logic        exp_valid;
      logic [71:0] exp_data;
      logic [8:0]  exp_empty;
   } vec_t;
   vec_t vt [11];

   function automatic void chk(string name, logic [71:0] act, logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic compare_all();
      logic [8:0] e_empty;
      logic [8:0] e_full;
      if (valid_out === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_valid: got valid with empty scoreboard, required none");
         end else begin
            chk("data_out", data_out, sb.pop_front());
         end
      end
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("count[%0d]", k), cnt[k], mq[k].size());
         e_empty[k] = (mq[k].size() == 0);
         e_full[k]  = (mq[k].size() >= depth - 3);
      end
      chk("empty_out", empty_out, e_empty);
      chk("full_out", full_out, e_full);
      chk("error", error, merr);
      chk("drained", drained, mstate == DONE);
      chk("state", dut.state, mstate);
   endtask

   task automatic step(input logic [8:0] we, input logic [7:0] b, input logic rr, input logic comp);
      logic        mpop;
      logic        any_e;
      logic        all_e;
      logic [71:0] col;
      logic [8:0]  acc;
      logic [1:0]  nerr;
      state_t      nst;
      write_enable_in = we;
      bus             = b;
      read_request    = rr;
      completed_in    = comp;
      any_e = 1'b0;
      all_e = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (mq[k].size() == 0) any_e = 1'b1;
         else                   all_e = 1'b0;
      end
      mpop = enable && rr && !any_e && (mstate == RUN || mstate == FLUSH);
      col = '0;
      if (mpop) begin
         for (int k = 0; k < 9; k++) col[k*8 +: 8] = mq[k][0];
         sb.push_back(col);
      end
      nerr = merr;
      if ($countones(we) > 1) nerr[0] = 1'b1;
      for (int k = 0; k < 9; k++) begin
         acc[k] = we[k] && (mq[k].size() < depth);
         if (we[k] && !acc[k]) nerr[0] = 1'b1;
      end
      nst = mstate;
      if (enable) begin
         case (mstate)
            IDLE:  nst = RUN;
            RUN:   if (comp || mcomp) nst = FLUSH;
            FLUSH: if (any_e) begin
                      nst = DONE;
                      if (!all_e) nerr[1] = 1'b1;
                   end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 9; k++) begin
         if (mpop)   void'(mq[k].pop_front());
         if (acc[k]) mq[k].push_back(b);
      end
      mstate = nst;
      merr   = nerr;
      mcomp  = mcomp | comp;
      chk("valid_out", valid_out, mpop);
      compare_all();
   endtask

   task automatic do_reset(input logic [8:0] we);
      reset           = 1'b0;
      write_enable_in = we;
      bus             = 8'hEE;
      read_request    = 1'b1;
      completed_in    = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 9; k++) mq[k].delete();
      chk("rst_sb_drained", sb.size(), 0);
      sb.delete();
      mstate = IDLE;
      mcomp  = 1'b0;
      merr   = 2'b00;
      for (int k = 0; k < 9; k++) chk($sformatf("rst_count[%0d]", k), cnt[k], 0);
      chk("rst_empty_out", empty_out, 9'h1FF);
      chk("rst_full_out", full_out, 9'h000);
      chk("rst_state", dut.state, IDLE);
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_drained", drained, 1'b0);
      chk("rst_error", error, 2'b00);
      chk("rst_data_out", data_out, 72'h0);
      reset           = 1'b1;
      write_enable_in = '0;
      read_request    = 1'b0;
      completed_in    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      reset = 1'b0;
      enable = 1'b1;
      bus = '0;
      write_enable_in = '0;
      completed_in = 1'b0;
      read_request = 1'b0;
      mstate = IDLE;
      mcomp = 1'b0;
      merr = 2'b00;

      // Basic fill of every lane then one aligned column.
      for (int i = 0; i < 9; i++) begin
         vt[i].we        = 9'd1 << i;
         vt[i].bus       = 8'h11 + 8'(i);
         vt[i].rr        = 1'b0;
         vt[i].exp_valid = 1'b0;
         vt[i].exp_data  = '0;
         vt[i].exp_empty = 9'h1FF << (i + 1);
      end
      vt[9].we = '0;  vt[9].bus = '0;  vt[9].rr = 1'b1;  vt[9].exp_valid = 1'b1;
      vt[9].exp_data = 72'h19_18_17_16_15_14_13_12_11;  vt[9].exp_empty = 9'h1FF;
      vt[10].we = '0; vt[10].bus = '0; vt[10].rr = 1'b1; vt[10].exp_valid = 1'b0;
      vt[10].exp_data = '0; vt[10].exp_empty = 9'h1FF;

      do_reset(9'h000);
      for (int i = 0; i < 11; i++) begin
         step(vt[i].we, vt[i].bus, vt[i].rr, 1'b0);
         chk($sformatf("tbl_valid[%0d]", i), valid_out, vt[i].exp_valid);
         if (vt[i].exp_valid) chk($sformatf("tbl_data[%0d]", i), data_out, vt[i].exp_data);
         chk($sformatf("tbl_empty[%0d]", i), empty_out, vt[i].exp_empty);
      end

      // Single-lane fill to threshold and overflow.
      do_reset(9'h000);
      for (int i = 1; i <= 17; i++) begin
         step(9'h008, 8'(i), 1'b0, 1'b0);
         if (i == 12) chk("full3_at_12", full_out[3], 1'b0);
         if (i == 13) chk("full3_at_13", full_out[3], 1'b1);
         if (i == 16) chk("ovf_at_16", error[0], 1'b0);
         if (i == 17) begin
            chk("ovf_at_17", error[0], 1'b1);
            chk("cnt3_at_17", cnt[3], 5'd16);
         end
      end

      // Same-cycle push and pop on a lane holding five words; enable gating.
      do_reset(9'h000);
      for (int i = 0; i < 5; i++) step(9'h001, 8'hA0 + 8'(i), 1'b0, 1'b0);
      for (int k = 1; k < 9; k++) step(9'd1 << k, 8'hB0 + 8'(k), 1'b0, 1'b0);
      enable = 1'b0;
      step(9'h000, 8'h00, 1'b1, 1'b0);
      chk("gated_valid", valid_out, 1'b0);
      chk("gated_cnt0", cnt[0], 5'd5);
      enable = 1'b1;
      step(9'h001, 8'hA5, 1'b1, 1'b0);
      chk("pp_valid", valid_out, 1'b1);
      chk("pp_lane0", data_out[7:0], 8'hA0);
      chk("pp_cnt0", cnt[0], 5'd5);

      // Four-deep fill then flush to completion.
      do_reset(9'h000);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 9; k++)
            step(9'd1 << k, 8'(k * 16 + i), 1'b0, 1'b0);
      pulses = 0;
      for (int n = 0; n < 20; n++) begin
         step(9'h000, 8'h00, 1'b1, 1'b1);
         if (valid_out) pulses++;
         if (drained) break;
      end
      chk("flush_pulses", pulses, 4);
      chk("flush_drained", drained, 1'b1);
      chk("flush_error", error, 2'b00);

      // Only one lane filled: flush reports misalignment.
      do_reset(9'h000);
      step(9'h004, 8'h21, 1'b0, 1'b0);
      step(9'h004, 8'h22, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++) begin
         step(9'h000, 8'h00, 1'b0, 1'b1);
         if (drained) break;
      end
      chk("mis_error", error, 2'b10);
      chk("mis_drained", drained, 1'b1);
      chk("mis_state", dut.state, DONE);

      // Reset with lanes half full and a strobe in the reset cycle.
      do_reset(9'h000);
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 9; k++)
            step(9'd1 << k, 8'(i * 9 + k), 1'b0, 1'b0);
      chk("half_cnt4", cnt[4], 5'd8);
      do_reset(9'h1FF);
      step(9'h000, 8'h00, 1'b0, 1'b0);
      chk("post_rst_valid", valid_out, 1'b0);

      // Multi-hot strobe pushes every flagged lane and flags overflow.
      step(9'h003, 8'h5A, 1'b0, 1'b0);
      chk("mh_error0", error[0], 1'b1);
      chk("mh_cnt0", cnt[0], 5'd1);
      chk("mh_cnt1", cnt[1], 5'd1);

      chk("sb_empty_end", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
